seg7_scan_driver: RTL

Multiplexed three-digit 7-segment display driver that sits directly downstream of the binary-to-BCD converter. It consumes the 12-bit packed BCD word (hundreds, tens, ones) and time-multiplexes it onto a common-segment display: digit scan prescaler, frame-aligned tear-free value update with acknowledge, leading-zero blanking and invalid-digit indication.

---
 rtl/seg7_scan_driver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Three-digit multiplexed 7-segment driver for a packed BCD word with frame-aligned
// tear-free updates, leading-zero blanking and dash display for non-decimal nibbles.
module seg7_scan_driver #(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] bcd,
   input  logic        bcd_load,
   input  logic        blank_lz,
   input  logic        enable,
   output logic [6:0]  seg,
   output logic [2:0]  an,
   output logic        load_ack
);

   localparam int unsigned  CW       = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [6:0]   SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0]   AN_OFF   = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

   typedef enum logic [1:0] {
      DIG_ONES     = 2'd0,
      DIG_TENS     = 2'd1,
      DIG_HUNDREDS = 2'd2
   } digit_t;

   digit_t        state;
   digit_t        state_next;
   logic [CW-1:0] cnt;
   logic          wrap;
   logic          frame_end;
   logic          commit;
   logic [11:0]   disp;
   logic [11:0]   pend_val;
   logic          pend;
   logic [3:0]    nib;
   logic          blank;
   logic [2:0]    an_onehot;
   logic [6:0]    code;
   logic [6:0]    seg_next;
   logic [2:0]    an_next;

   assign wrap      = (cnt == CNT_LAST);
   assign frame_end = wrap && (state == DIG_HUNDREDS);
   assign commit    = frame_end && (pend || bcd_load);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DIG_ONES;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (wrap) begin
         case (state)
            DIG_ONES: state_next = DIG_TENS;
            DIG_TENS: state_next = DIG_HUNDREDS;
            default:  state_next = DIG_ONES;
         endcase
      end
   end

   // Same-cycle load at the frame boundary bypasses the pending register so it wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp     <= '0;
         pend_val <= '0;
         pend     <= 1'b0;
         load_ack <= 1'b0;
      end else begin
         load_ack <= commit;
         if (commit) begin
            disp     <= bcd_load ? bcd : pend_val;
            pend_val <= bcd_load ? bcd : pend_val;
            pend     <= 1'b0;
         end else if (bcd_load) begin
            pend_val <= bcd;
            pend     <= 1'b1;
         end
      end
   end

   always_comb begin
      nib       = disp[3:0];
      blank     = 1'b0;
      an_onehot = 3'b001;
      case (state)
         DIG_ONES: begin
            nib       = disp[3:0];
            an_onehot = 3'b001;
         end
         DIG_TENS: begin
            nib       = disp[7:4];
            blank     = blank_lz && (disp[11:8] == 4'd0) && (disp[7:4] == 4'd0);
            an_onehot = 3'b010;
         end
         default: begin
            nib       = disp[11:8];
            blank     = blank_lz && (disp[11:8] == 4'd0);
            an_onehot = 3'b100;
         end
      endcase

      case (nib)
         4'd0:    code = 7'h3F;
         4'd1:    code = 7'h06;
         4'd2:    code = 7'h5B;
         4'd3:    code = 7'h4F;
         4'd4:    code = 7'h66;
         4'd5:    code = 7'h6D;
         4'd6:    code = 7'h7D;
         4'd7:    code = 7'h07;
         4'd8:    code = 7'h7F;
         4'd9:    code = 7'h6F;
         default: code = 7'h40;
      endcase

      if (!enable || blank) begin
         seg_next = SEG_OFF;
         an_next  = AN_OFF;
      end else begin
         seg_next = SEG_ACTIVE_LOW ? ~code : code;
         an_next  = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= seg_next;
         an  <= an_next;
      end
   end

endmodule
